// File: rtl/uart_pkg.sv
// Shared UART types and defaults: the transmitter state encoding and
// the default clock/baud figures used by every UART block.
package uart_pkg;

   localparam int unsigned UART_DEFAULT_CLK  = 50000000;
   localparam int unsigned UART_DEFAULT_BAUD = 115200;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

   // Rounded-to-nearest clock cycles per serial bit.
   function automatic int unsigned baud_div(input int unsigned clk_freq,
                                            input int unsigned baud_rate);
      return (clk_freq + baud_rate / 2) / baud_rate;
   endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-stream valid/ready handshake into the UART transmitter.
interface uart_tx_fifo_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and an
// occupancy count; pushes when full and pops when empty are dropped.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; resetting the pointers and
   // count already discards the contents and keeps the array RAM-mappable.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered 8N1 UART transmitter: bytes queue in sync_fifo and are
// serialised back-to-back by a baud-timed IDLE/START/DATA/STOP machine.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = UART_DEFAULT_CLK,
   parameter int unsigned BAUD_RATE  = UART_DEFAULT_BAUD,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   uart_tx_fifo_if.slave                tx_if,
   output logic                         uart_tx,
   output logic                         busy,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

   localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD_RATE);
   localparam int unsigned CW  = $clog2(DIV + 1);

   tx_state_t      state_q, state_d;
   logic [CW-1:0]  baud_cnt_q, baud_cnt_d;
   logic [2:0]     bit_idx_q, bit_idx_d;
   logic [7:0]     shift_q, shift_d;
   logic           uart_tx_q, tx_bit;
   logic           ready_en_q;
   logic           fifo_pop, fifo_full, fifo_empty;
   logic [7:0]     fifo_rdata;
   logic           baud_done;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (tx_if.tx_valid && tx_if.tx_ready),
      .wdata_i (tx_if.tx_data),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // ready_en_q holds tx_ready low through reset and for the release edge.
   assign tx_if.tx_ready = ready_en_q && !fifo_full;
   assign uart_tx        = uart_tx_q;
   assign busy           = (state_q != IDLE) || !fifo_empty;
   assign baud_done      = (baud_cnt_q == CW'(DIV - 1));

   // NOTE: every always_comb output gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_done ? '0 : baud_cnt_q + 1'b1;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      fifo_pop   = 1'b0;
      tx_bit     = 1'b1;
      case (state_q)
         IDLE: begin
            baud_cnt_d = '0;
            bit_idx_d  = '0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_rdata;
               state_d  = START;
            end
         end
         START: begin
            tx_bit = 1'b0;
            if (baud_done) state_d = DATA;
         end
         DATA: begin
            tx_bit = shift_q[bit_idx_q];
            if (baud_done) begin
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (baud_done) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_rdata;
                  state_d  = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The line is registered from the current state, so it trails the FSM
   // by one cycle uniformly and never glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         baud_cnt_q <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         uart_tx_q  <= 1'b1;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         uart_tx_q  <= tx_bit;
         ready_en_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: scoreboard of pushed bytes against a mid-bit
// sampling serial receiver, plus exact-timing checks of one default frame.
module tb_uart_tx_fifo;

   localparam int CF      = 1000000;
   localparam int BR      = 90000;
   localparam int DIV     = (CF + BR / 2) / BR;
   localparam int DIV_DEF = (50000000 + 115200 / 2) / 115200;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_fifo_if bus ();
   uart_tx_fifo_if bus_def ();
   logic       uart_tx, busy, uart_tx_def, busy_def;
   logic [4:0] fifo_count, fifo_count_def;

   uart_tx_fifo #(.CLK_FREQ(CF), .BAUD_RATE(BR), .FIFO_DEPTH(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .tx_if(bus.slave),
      .uart_tx(uart_tx), .busy(busy), .fifo_count(fifo_count)
   );

   uart_tx_fifo u_dut_def (
      .clk(clk), .rst_n(rst_n), .tx_if(bus_def.slave),
      .uart_tx(uart_tx_def), .busy(busy_def), .fifo_count(fifo_count_def)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int rx_count = 0;
   logic [7:0] exp_q[$];
   int start_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Receiver: detect start, sample each bit at its centre, score the byte.
   initial begin : rx
      logic [9:0] bits;
      bit         abort;
      int         st;
      forever begin
         @(negedge clk);
         if (rst_n && uart_tx === 1'b0) begin
            st    = cyc;
            abort = 0;
            bits  = '0;
            for (int k = 1; k <= DIV / 2 + 9 * DIV; k++) begin
               @(negedge clk);
               if (!rst_n) abort = 1;
               if (k >= DIV / 2 && (k - DIV / 2) % DIV == 0) bits[(k - DIV / 2) / DIV] = uart_tx;
            end
            if (!abort) begin
               start_q.push_back(st);
               rx_count++;
               check("rx_start_bit", bits[0], 1'b0);
               check("rx_stop_bit", bits[9], 1'b1);
               check("rx_pending", exp_q.size() > 0, 1'b1);
               if (exp_q.size() > 0) check("rx_data", bits[8:1], exp_q.pop_front());
            end
         end
      end
   end

   task automatic send(input logic [7:0] d, output bit acc);
      bus.tx_data  = d;
      bus.tx_valid = 1'b1;
      acc = bus.tx_ready;
      if (acc) exp_q.push_back(d);
      @(negedge clk);
      bus.tx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (!busy && exp_q.size() == 0) break;
         @(negedge clk);
      end
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_queue"}, exp_q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_gaps(input string tag, input int n);
      check({tag, "_frames"}, start_q.size(), n);
      for (int i = 1; i < start_q.size(); i++)
         check({tag, "_gap"}, start_q[i] - start_q[i-1], 10 * DIV);
   endtask

   initial begin : watchdog
      #800000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [9:0] f55;
      logic [7:0] stream [40];
      bit   acc;
      int   nacc, n_a5, max_cnt, idx, guard, rx0;
      bit   low_seen;

      bus.tx_valid = 1'b0;  bus.tx_data = '0;
      bus_def.tx_valid = 1'b0;  bus_def.tx_data = '0;
      f55 = {1'b1, 8'h55, 1'b0};

      // Reset values and tx_ready rising on the first edge after release.
      repeat (3) @(negedge clk);
      check("rst_line", uart_tx, 1'b1);
      check("rst_ready", bus.tx_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_count", fifo_count, 0);
      #2 rst_n = 1'b1;
      #1 check("ready_before_edge", bus.tx_ready, 1'b0);
      @(posedge clk);
      #1 check("ready_after_edge", bus.tx_ready, 1'b1);
      @(negedge clk);

      // Default parameters: one 0x55 frame with exact 434-cycle bits.
      check("def_ready", bus_def.tx_ready, 1'b1);
      bus_def.tx_data = 8'h55;  bus_def.tx_valid = 1'b1;
      @(negedge clk);
      bus_def.tx_valid = 1'b0;
      for (int c = 1; c <= 10 * DIV_DEF + 2; c++) begin
         @(negedge clk);
         if (c == 1) check("def_lat_edge1", uart_tx_def, 1'b1);
         if (c == 2) check("def_lat_edge2", uart_tx_def, 1'b0);
         if (c == 1 + DIV_DEF) check("def_start_last", uart_tx_def, 1'b0);
         if (c == 2 + DIV_DEF) check("def_bit0_first", uart_tx_def, 1'b1);
         if (c >= 2 && (c - 2) % DIV_DEF == DIV_DEF / 2)
            check("def_bit", uart_tx_def, f55[(c - 2) / DIV_DEF]);
         if (c == 10 * DIV_DEF) check("def_busy_stop", busy_def, 1'b1);
         if (c == 10 * DIV_DEF + 1) check("def_busy_idle", busy_def, 1'b0);
      end

      // Burst of 16 bytes in consecutive cycles; first is popped at once.
      start_q.delete();
      nacc = 0;
      for (int i = 0; i < 16; i++) begin
         send(8'(i), acc);
         nacc += int'(acc);
      end
      check("burst_accepted", nacc, 16);
      check("burst_count", fifo_count, 15);
      check("burst_ready", bus.tx_ready, 1'b1);
      wait_idle("burst", 20 * 10 * DIV);
      check_gaps("burst", 16);

      // Fill to full, then hold 0xA5 valid against a full FIFO.
      start_q.delete();
      nacc = 0;
      for (int i = 0; i < 17; i++) begin
         send(8'h10 + 8'(i), acc);
         nacc += int'(acc);
      end
      check("fill_accepted", nacc, 17);
      check("full_count", fifo_count, 16);
      check("full_ready", bus.tx_ready, 1'b0);
      n_a5 = 0;
      max_cnt = 0;
      for (int i = 0; i < 30 * DIV; i++) begin
         send(8'hA5, acc);
         n_a5 += int'(acc);
         if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      end
      check("hold_max_count", max_cnt, 16);
      wait_idle("hold", 30 * 10 * DIV);
      check_gaps("hold", 17 + n_a5);

      // Push on the same edge as the STOP->START pop.
      send(8'h3C, acc);
      send(8'hC3, acc);
      repeat (10 * DIV - 1) @(negedge clk);
      check("pp_count_before", fifo_count, 1);
      check("pp_line_stop", uart_tx, 1'b1);
      send(8'h5A, acc);
      check("pp_accepted", acc, 1'b1);
      check("pp_count_after", fifo_count, 1);
      @(negedge clk);
      check("pp_next_start", uart_tx, 1'b0);
      wait_idle("pp", 4 * 10 * DIV);

      // Asynchronous reset in the middle of data bit 3 of 0xFF.
      send(8'hFF, acc);
      send(8'h77, acc);
      repeat (1 + 4 * DIV + DIV / 2) @(negedge clk);
      check("mid_line", uart_tx, 1'b1);
      check("mid_count", fifo_count, 1);
      check("mid_busy", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("async_line", uart_tx, 1'b1);
      check("async_count", fifo_count, 0);
      check("async_ready", bus.tx_ready, 1'b0);
      check("async_busy", busy, 1'b0);
      exp_q.delete();
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      start_q.delete();
      low_seen = 0;
      for (int i = 0; i < 30 * DIV; i++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) low_seen = 1;
      end
      check("post_rst_line", low_seen, 1'b0);
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_frames", start_q.size(), 0);

      // 40 random bytes streamed continuously, wrapping the pointers.
      for (int i = 0; i < 40; i++) stream[i] = 8'($urandom_range(0, 255));
      start_q.delete();
      rx0 = rx_count;
      idx = 0;
      guard = 0;
      while (idx < 40 && guard < 100 * 10 * DIV) begin
         send(stream[idx], acc);
         if (acc) idx++;
         guard++;
      end
      check("stream_sent", idx, 40);
      wait_idle("stream", 60 * 10 * DIV);
      check("stream_received", rx_count - rx0, 40);
      check_gaps("stream", 40);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
